// File: rtl/alu_share_arbiter_if.sv
// Purpose : bundles the request, ALU-side and response signals of the shared-ALU arbiter.
// Latency : n/a (wiring only).
// Backpressure: req_valid/req_ready per requester, rsp_valid/rsp_ready on the response.
// Ports   : master = client/ALU side (drives requests, ALU results, rsp_ready);
//           slave  = arbiter side (drives req_ready, ALU operands, response, busy).
interface alu_share_arbiter_if #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [8*NREQ-1:0] req_a;
    logic [8*NREQ-1:0] req_b;
    logic [2*NREQ-1:0] req_op;

    logic [7:0]        alu_a;
    logic [7:0]        alu_b;
    logic [1:0]        alu_op;
    logic              alu_oe;
    logic [7:0]        alu_y;
    logic [4:0]        alu_flags;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [7:0]        rsp_y;
    logic [4:0]        rsp_flags;
    logic              busy;

    modport master (
        output req_valid, req_a, req_b, req_op, alu_y, alu_flags, rsp_ready,
        input  req_ready, alu_a, alu_b, alu_op, alu_oe,
        input  rsp_valid, rsp_id, rsp_y, rsp_flags, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, alu_y, alu_flags, rsp_ready,
        output req_ready, alu_a, alu_b, alu_op, alu_oe,
        output rsp_valid, rsp_id, rsp_y, rsp_flags, busy
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Purpose : round-robin sharing of one 8-bit combinational ALU among NREQ requesters.
// Latency : grant edge to rsp_valid = ALU_LAT cycles; one op per ALU_LAT+2 cycles peak.
// Backpressure: no grants outside IDLE; response held while rsp_valid & !rsp_ready.
// Ports   : clk, rst (synchronous, active high); bus (slave modport) carries the
//           request bus, registered ALU operands/results and the tagged response.
module alu_share_arbiter #(
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int ALU_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    alu_share_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]  id_q, id_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [7:0]      alu_a_q, alu_a_d;
    logic [7:0]      alu_b_q, alu_b_d;
    logic [1:0]      alu_op_q, alu_op_d;
    logic            alu_oe_q, alu_oe_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]  rsp_id_q, rsp_id_d;
    logic [7:0]      rsp_y_q, rsp_y_d;
    logic [4:0]      rsp_flags_q, rsp_flags_d;

    logic            grant_vld;
    logic [IDW-1:0]  grant_idx;
    logic [IDW-1:0]  cand;
    logic [NREQ-1:0] grant_onehot;

    // Round-robin scan starting at rr_ptr; the first valid requester wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = IDW'((int'(rr_ptr_q) + k) % NREQ);
            if (!grant_vld && bus.req_valid[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    assign grant_onehot = NREQ'(1) << grant_idx;

    // Accept only in IDLE; masked during reset so no handshake is seen on an edge
    // that is about to be discarded.
    assign bus.req_ready = (state_q == IDLE && grant_vld && !rst) ? grant_onehot : '0;

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        id_d        = id_q;
        cnt_d       = cnt_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_op_d    = alu_op_q;
        alu_oe_d    = alu_oe_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_y_d     = rsp_y_q;
        rsp_flags_d = rsp_flags_q;

        case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    alu_a_d  = bus.req_a[{grant_idx, 3'b000} +: 8];
                    alu_b_d  = bus.req_b[{grant_idx, 3'b000} +: 8];
                    alu_op_d = bus.req_op[{grant_idx, 1'b0} +: 2];
                    alu_oe_d = 1'b1;
                    id_d     = grant_idx;
                    rr_ptr_d = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
                    cnt_d    = 4'(ALU_LAT - 1);
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                // Operands stay registered; sample the ALU once the count runs out.
                if (cnt_q == 4'd0) begin
                    rsp_y_d     = bus.alu_y;
                    rsp_flags_d = bus.alu_flags;
                    rsp_id_d    = id_q;
                    rsp_valid_d = 1'b1;
                    alu_oe_d    = 1'b0;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            id_q        <= '0;
            cnt_q       <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= '0;
            alu_oe_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_y_q     <= '0;
            rsp_flags_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            id_q        <= id_d;
            cnt_q       <= cnt_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_op_q    <= alu_op_d;
            alu_oe_q    <= alu_oe_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_y_q     <= rsp_y_d;
            rsp_flags_q <= rsp_flags_d;
        end
    end

    assign bus.alu_a     = alu_a_q;
    assign bus.alu_b     = alu_b_q;
    assign bus.alu_op    = alu_op_q;
    assign bus.alu_oe    = alu_oe_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_y     = rsp_y_q;
    assign bus.rsp_flags = rsp_flags_q;
    assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Purpose : directed self-checking bench for alu_share_arbiter with an ALU stub.
// Latency : DUT built with ALU_LAT=3; expected latency and spacing derive from LAT.
// Backpressure: exercises response stalls via rsp_ready and competing requesters.
module tb_alu_share_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int LAT  = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass  = 0;
    int n_total = 0;

    alu_share_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

    alu_share_arbiter #(.NREQ(NREQ), .IDW(IDW), .ALU_LAT(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // ALU stub: y by opcode, flags {less, is_eq, greater, overflow, parity}; zero when oe low.
    logic [8:0] stub_sum, stub_dif;
    logic [7:0] stub_y;
    logic       stub_ov;
    always_comb begin
        stub_sum = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
        stub_dif = {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
        stub_y   = 8'h00;
        stub_ov  = 1'b0;
        case (bus.alu_op)
            2'b00: begin stub_y = stub_sum[7:0]; stub_ov = stub_sum[8]; end
            2'b01: begin stub_y = stub_dif[7:0]; stub_ov = stub_dif[8]; end
            2'b10: stub_y = bus.alu_a & bus.alu_b;
            default: stub_y = bus.alu_a ^ bus.alu_b;
        endcase
        if (bus.alu_oe) begin
            bus.alu_y     = stub_y;
            bus.alu_flags = {bus.alu_a < bus.alu_b, bus.alu_a == bus.alu_b,
                             bus.alu_a > bus.alu_b, stub_ov, ^stub_y};
        end else begin
            bus.alu_y     = 8'h00;
            bus.alu_flags = 5'b00000;
        end
    end

    function automatic logic [39:0] outs();
        return {bus.req_ready, bus.alu_a, bus.alu_b, bus.alu_op, bus.alu_oe, bus.rsp_valid,
                bus.rsp_id, bus.rsp_y, bus.rsp_flags, bus.busy};
    endfunction

    task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b,
                           input logic [1:0] op);
        bus.req_a[8*i +: 8]  = a;
        bus.req_b[8*i +: 8]  = b;
        bus.req_op[2*i +: 2] = op;
    endtask

    // Called at negedge+1; returns when a handshake will happen on the coming posedge.
    task automatic wait_grant(output int gid, output int gcyc, output logic ok);
        ok = 1'b0; gid = -1; gcyc = 0;
        for (int k = 0; k < 60 && !ok; k++) begin
            if (|(bus.req_valid & bus.req_ready)) begin
                ok   = 1'b1;
                gcyc = cyc;
                for (int j = 0; j < NREQ; j++) if (bus.req_ready[j]) gid = j;
            end else begin
                @(negedge clk); #1;
            end
        end
    endtask

    // Called at the first negedge+1 after the grant edge; lat = posedges since grant.
    task automatic wait_rsp(output int lat, output logic ok);
        ok = 1'b0; lat = 0;
        for (int k = 0; k < 40 && !ok; k++) begin
            if (bus.rsp_valid) ok = 1'b1;
            else begin @(negedge clk); #1; lat++; end
        end
    endtask

    task automatic drain(output logic ok);
        bus.rsp_ready = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 60 && !ok; k++) begin
            if (!bus.busy && !bus.rsp_valid) ok = 1'b1;
            else begin @(negedge clk); #1; end
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #1;
        n_total++;
        if (outs() !== 40'h0) $display("FAIL reset_outputs: got %h expected %h", outs(), 40'h0);
        else n_pass++;
        @(negedge clk); rst = 1'b0; #1;
        n_total++;
        if (outs() !== 40'h0) $display("FAIL post_reset_idle: got %h expected %h", outs(), 40'h0);
        else n_pass++;
    endtask

    task automatic test_single();
        int lat; logic ok;
        set_req(2, 8'h3C, 8'h05, 2'b00);
        bus.req_valid = 4'b0100;
        bus.rsp_ready = 1'b1;
        #1;
        n_total++;
        if (bus.req_ready !== 4'b0100) $display("FAIL single_ready: got %b expected %b", bus.req_ready, 4'b0100);
        else n_pass++;
        @(negedge clk); #1;
        n_total++;
        if ({bus.req_ready, bus.alu_a, bus.alu_b, bus.alu_oe, bus.busy} !== {4'b0000, 8'h3C, 8'h05, 1'b1, 1'b1})
            $display("FAIL single_issue: ready=%b a=%h b=%h oe=%b busy=%b", bus.req_ready, bus.alu_a,
                     bus.alu_b, bus.alu_oe, bus.busy);
        else n_pass++;
        bus.req_valid = '0;
        wait_rsp(lat, ok);
        n_total++;
        if (!ok || lat != LAT) $display("FAIL single_latency: got %0d (seen=%b) expected %0d", lat, ok, LAT);
        else n_pass++;
        n_total++;
        if ({bus.rsp_id, bus.rsp_y, bus.rsp_flags, bus.alu_oe} !== {2'd2, 8'h41, 5'b00100, 1'b0})
            $display("FAIL single_rsp: id=%0d y=%h flags=%b oe=%b expected id=2 y=41 flags=00100 oe=0",
                     bus.rsp_id, bus.rsp_y, bus.rsp_flags, bus.alu_oe);
        else n_pass++;
        @(negedge clk); #1;
        n_total++;
        if ({bus.rsp_valid, bus.busy} !== 2'b00) $display("FAIL single_done: valid,busy=%b expected 00", {bus.rsp_valid, bus.busy});
        else n_pass++;
    endtask

    task automatic test_round_robin();
        int gid, gcyc, prev; logic ok;
        apply_reset();
        for (int i = 0; i < NREQ; i++) set_req(i, 8'(i + 1), 8'h01, 2'b00);
        bus.req_valid = 4'b1111;
        bus.rsp_ready = 1'b1;
        prev = 0;
        #1;
        for (int g = 0; g < 5; g++) begin
            wait_grant(gid, gcyc, ok);
            n_total++;
            if (!ok || gid != g % NREQ) $display("FAIL rr_order[%0d]: got %0d (seen=%b) expected %0d", g, gid, ok, g % NREQ);
            else n_pass++;
            if (g > 0) begin
                n_total++;
                if (gcyc - prev != LAT + 2) $display("FAIL rr_spacing[%0d]: got %0d expected %0d", g, gcyc - prev, LAT + 2);
                else n_pass++;
            end
            prev = gcyc;
            @(negedge clk); #1;
        end
        bus.req_valid = '0;
        drain(ok);
        n_total++;
        if (!ok) $display("FAIL rr_drain: timeout busy=%b expected 0", bus.busy);
        else n_pass++;
    endtask

    task automatic test_stall();
        int gid, gcyc, lat; logic ok;
        set_req(0, 8'h07, 8'h07, 2'b01);
        bus.req_valid = 4'b0001;
        bus.rsp_ready = 1'b0;
        #1;
        wait_grant(gid, gcyc, ok);
        n_total++;
        if (!ok || gid != 0) $display("FAIL stall_grant: got %0d expected 0", gid);
        else n_pass++;
        @(negedge clk); #1;
        bus.req_valid = 4'b1110;
        wait_rsp(lat, ok);
        n_total++;
        if (!ok) $display("FAIL stall_rsp: timeout rsp_valid=%b expected 1", bus.rsp_valid);
        else n_pass++;
        for (int s = 0; s < 5; s++) begin
            n_total++;
            if ({bus.rsp_valid, bus.rsp_y, bus.rsp_flags, bus.req_ready} !== {1'b1, 8'h00, 5'b01000, 4'b0000})
                $display("FAIL stall_hold[%0d]: valid=%b y=%h flags=%b ready=%b expected 1 00 01000 0000",
                         s, bus.rsp_valid, bus.rsp_y, bus.rsp_flags, bus.req_ready);
            else n_pass++;
            @(negedge clk); #1;
        end
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        @(negedge clk); #1;
        n_total++;
        if (bus.rsp_valid !== 1'b0) $display("FAIL stall_release: rsp_valid=%b expected 0", bus.rsp_valid);
        else n_pass++;
        drain(ok);
    endtask

    task automatic test_wrap();
        int gid, gcyc; logic ok;
        apply_reset();
        bus.req_valid = 4'b0100;
        #1;
        wait_grant(gid, gcyc, ok);
        @(negedge clk); #1;
        bus.req_valid = '0;
        drain(ok);
        bus.req_valid = 4'b0010;
        #1;
        wait_grant(gid, gcyc, ok);
        n_total++;
        if (!ok || gid != 1) $display("FAIL wrap_grant: got %0d expected 1", gid);
        else n_pass++;
        @(negedge clk); #1;
        bus.req_valid = '0;
        drain(ok);
        bus.req_valid = 4'b1111;
        #1;
        wait_grant(gid, gcyc, ok);
        n_total++;
        if (!ok || gid != 2) $display("FAIL wrap_next_ptr: got %0d expected 2", gid);
        else n_pass++;
        @(negedge clk); #1;
        bus.req_valid = '0;
        drain(ok);
    endtask

    task automatic test_reset_abort();
        int gid, gcyc, lat; logic ok, seen;
        set_req(3, 8'h11, 8'h22, 2'b00);
        bus.req_valid = 4'b1000;
        #1;
        wait_grant(gid, gcyc, ok);
        @(negedge clk); #1;
        bus.req_valid = '0;
        n_total++;
        if (bus.busy !== 1'b1) $display("FAIL abort_in_wait: busy=%b expected 1", bus.busy);
        else n_pass++;
        rst = 1'b1;
        @(negedge clk); #1;
        n_total++;
        if (outs() !== 40'h0) $display("FAIL abort_outputs: got %h expected %h", outs(), 40'h0);
        else n_pass++;
        rst = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk); #1;
            if (bus.rsp_valid) seen = 1'b1;
        end
        n_total++;
        if (seen !== 1'b0) $display("FAIL abort_no_rsp: rsp_valid seen=%b expected 0", seen);
        else n_pass++;
        bus.req_valid = 4'b1111;
        bus.rsp_ready = 1'b1;
        #1;
        wait_grant(gid, gcyc, ok);
        n_total++;
        if (!ok || gid != 0) $display("FAIL abort_fresh_grant: got %0d expected 0", gid);
        else n_pass++;
        @(negedge clk); #1;
        bus.req_valid = '0;
        wait_rsp(lat, ok);
        n_total++;
        if (!ok || lat != LAT || bus.rsp_id !== 2'd0 || bus.rsp_y !== 8'h00)
            $display("FAIL abort_fresh_rsp: lat=%0d id=%0d y=%h expected lat=%0d id=0 y=00", lat, bus.rsp_id, bus.rsp_y, LAT);
        else n_pass++;
        drain(ok);
    endtask

    task automatic test_latency3();
        int gid, gcyc, lat; logic ok, stable;
        set_req(1, 8'hF0, 8'h3C, 2'b10);
        bus.req_valid = 4'b0010;
        bus.rsp_ready = 1'b1;
        #1;
        wait_grant(gid, gcyc, ok);
        n_total++;
        if (!ok || gid != 1) $display("FAIL lat3_grant: got %0d expected 1", gid);
        else n_pass++;
        @(negedge clk); #1;
        bus.req_valid = '0;
        stable = 1'b1;
        lat = 0;
        ok = 1'b0;
        for (int k = 0; k < 40 && !ok; k++) begin
            if (bus.rsp_valid) ok = 1'b1;
            else begin
                if ({bus.alu_a, bus.alu_b, bus.alu_op, bus.alu_oe} !== {8'hF0, 8'h3C, 2'b10, 1'b1}) stable = 1'b0;
                @(negedge clk); #1;
                lat++;
            end
        end
        n_total++;
        if (!ok || lat != 3) $display("FAIL lat3_latency: got %0d (seen=%b) expected 3", lat, ok);
        else n_pass++;
        n_total++;
        if (stable !== 1'b1) $display("FAIL lat3_operands_stable: got %b expected 1", stable);
        else n_pass++;
        n_total++;
        if ({bus.rsp_id, bus.rsp_y, bus.rsp_flags} !== {2'd1, 8'h30, 5'b00100})
            $display("FAIL lat3_rsp: id=%0d y=%h flags=%b expected id=1 y=30 flags=00100", bus.rsp_id, bus.rsp_y, bus.rsp_flags);
        else n_pass++;
        n_total++;
        if ({bus.alu_a, bus.alu_b, bus.alu_op, bus.alu_oe} !== {8'hF0, 8'h3C, 2'b10, 1'b0})
            $display("FAIL lat3_operands_kept: a=%h b=%h op=%b oe=%b expected F0 3C 10 0",
                     bus.alu_a, bus.alu_b, bus.alu_op, bus.alu_oe);
        else n_pass++;
        drain(ok);
        n_total++;
        if (!ok) $display("FAIL lat3_drain: timeout busy=%b expected 0", bus.busy);
        else n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1);
    end

    initial begin
        rst           = 1'b1;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_op    = '0;
        bus.rsp_ready = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_stall();
        test_wrap();
        test_reset_abort();
        test_latency3();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
